// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter feeding one 8-bit UART
// AXI-Stream slave from NUM_REQ requesters, with an optional source header byte.
module uart_tx_arbiter #(
  parameter int         NUM_REQ    = 4,
  parameter int         DATA_WIDTH = 8,
  parameter bit         ADD_HEADER = 1'b1,
  parameter logic [3:0] HDR_TAG    = 4'hA
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] slv_axis_tdata_i,
  input  logic [NUM_REQ-1:0]            slv_axis_tvalid_i,
  input  logic [NUM_REQ-1:0]            slv_axis_tlast_i,
  output logic [NUM_REQ-1:0]            slv_axis_tready_o,
  output logic [DATA_WIDTH-1:0]         mst_axis_tdata_o,
  output logic                          mst_axis_tvalid_o,
  output logic                          mst_axis_tlast_o,
  input  logic                          mst_axis_tready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          pkt_done_o
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_STREAM} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      cur_idx_q, cur_idx_d;
  logic [IW-1:0]      last_idx_q, last_idx_d;
  logic               pkt_done_q, pkt_done_d;

  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [DATA_WIDTH-1:0] lane_data;
  logic               lane_vld;
  logic               lane_last;
  logic [3:0]         hdr_nib;

  // Round-robin search starting just after the last served requester.
  always_comb begin
    logic [IW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(last_idx_q) + i) % NUM_REQ);
      if (!pick_vld && slv_axis_tvalid_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Select the granted requester's lanes for the pass-through path.
  always_comb begin
    lane_data = '0;
    lane_vld  = 1'b0;
    lane_last = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cur_idx_q == IW'(k)) begin
        lane_data = slv_axis_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        lane_vld  = slv_axis_tvalid_i[k];
        lane_last = slv_axis_tlast_i[k];
      end
    end
  end

  // Header low nibble is the source index, zero-extended.
  always_comb begin
    hdr_nib         = '0;
    hdr_nib[IW-1:0] = cur_idx_q;
  end

  // Next-state and output decode; the grant stays locked until tlast transfers.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    cur_idx_d         = cur_idx_q;
    last_idx_d        = last_idx_q;
    pkt_done_d        = 1'b0;
    mst_axis_tdata_o  = '0;
    mst_axis_tvalid_o = 1'b0;
    mst_axis_tlast_o  = 1'b0;
    slv_axis_tready_o = '0;
    case (state_q)
      S_IDLE: begin
        if (en_i && pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          cur_idx_d         = pick_idx;
          state_d           = ADD_HEADER ? S_HEADER : S_STREAM;
        end
      end
      S_HEADER: begin
        // Offered unconditionally so valid never drops before the handshake.
        mst_axis_tvalid_o = 1'b1;
        mst_axis_tdata_o  = {HDR_TAG, hdr_nib};
        if (mst_axis_tready_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        mst_axis_tdata_o             = lane_data;
        mst_axis_tvalid_o            = lane_vld;
        mst_axis_tlast_o             = lane_last;
        slv_axis_tready_o[cur_idx_q] = mst_axis_tready_i;
        if (lane_vld && mst_axis_tready_i && lane_last) begin
          last_idx_d = cur_idx_q;
          grant_d    = '0;
          pkt_done_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset makes requester 0 the first in line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      cur_idx_q  <= '0;
      last_idx_q <= IW'(NUM_REQ - 1);
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cur_idx_q  <= cur_idx_d;
      last_idx_q <= last_idx_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = (state_q != S_IDLE);
  assign pkt_done_o = pkt_done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one task per scenario, requester model
// replays per-lane byte lists and advances on its own handshakes.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, mst_tready;
  logic [31:0] slv_tdata;
  logic [3:0]  slv_tvalid, slv_tlast;

  logic [3:0] r0_ready, r1_ready, g0, g1;
  logic [7:0] d0, d1;
  logic       v0, v1, l0, l1, b0, b1, p0, p1;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADD_HEADER(1'b1), .HDR_TAG(4'hA)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .slv_axis_tdata_i(slv_tdata), .slv_axis_tvalid_i(slv_tvalid), .slv_axis_tlast_i(slv_tlast),
    .slv_axis_tready_o(r0_ready),
    .mst_axis_tdata_o(d0), .mst_axis_tvalid_o(v0), .mst_axis_tlast_o(l0),
    .mst_axis_tready_i(mst_tready),
    .grant_o(g0), .busy_o(b0), .pkt_done_o(p0)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADD_HEADER(1'b0), .HDR_TAG(4'hA)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .slv_axis_tdata_i(slv_tdata), .slv_axis_tvalid_i(slv_tvalid), .slv_axis_tlast_i(slv_tlast),
    .slv_axis_tready_o(r1_ready),
    .mst_axis_tdata_o(d1), .mst_axis_tvalid_o(v1), .mst_axis_tlast_o(l1),
    .mst_axis_tready_i(mst_tready),
    .grant_o(g1), .busy_o(b1), .pkt_done_o(p1)
  );

  // Which DUT the requester model and capture follow.
  logic sel = 1'b0;

  logic [3:0] s_ready, s_grant;
  logic [7:0] s_data;
  logic       s_valid, s_last, s_busy, s_done;

  logic [7:0] pk_d [4][8];
  logic       pk_l [4][8];
  int         pk_len [4];
  int         pk_pos [4];

  logic [7:0] out_d [32];
  logic       out_l [32];
  logic [3:0] out_g [32];
  int         out_c [32];
  int         n, done_cnt, cyc;
  int         tests = 0, fails = 0;

  task automatic apply();
    for (int k = 0; k < 4; k++) begin
      if (pk_pos[k] < pk_len[k]) begin
        slv_tvalid[k]        = 1'b1;
        slv_tdata[k*8 +: 8]  = pk_d[k][pk_pos[k]];
        slv_tlast[k]         = pk_l[k][pk_pos[k]];
      end else begin
        slv_tvalid[k]        = 1'b0;
        slv_tdata[k*8 +: 8]  = 8'h00;
        slv_tlast[k]         = 1'b0;
      end
    end
  endtask

  task automatic clr_model();
    for (int k = 0; k < 4; k++) begin
      pk_len[k] = 0;
      pk_pos[k] = 0;
    end
    n = 0; done_cnt = 0; cyc = 0;
  endtask

  task automatic load(input int k, input int idx, input logic [7:0] d, input logic l);
    pk_d[k][idx] = d;
    pk_l[k][idx] = l;
    if (idx + 1 > pk_len[k]) pk_len[k] = idx + 1;
  endtask

  // One clock: sample at negedge, advance requesters just after posedge.
  task automatic tick();
    logic [3:0] hs;
    @(negedge clk);
    s_ready = sel ? r1_ready : r0_ready;
    s_grant = sel ? g1 : g0;
    s_data  = sel ? d1 : d0;
    s_valid = sel ? v1 : v0;
    s_last  = sel ? l1 : l0;
    s_busy  = sel ? b1 : b0;
    s_done  = sel ? p1 : p0;
    if (s_valid === 1'b1 && mst_tready && n < 32) begin
      out_d[n] = s_data; out_l[n] = s_last; out_g[n] = s_grant; out_c[n] = cyc;
      n++;
    end
    if (s_done === 1'b1) done_cnt++;
    hs = slv_tvalid & s_ready;
    cyc++;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (hs[k] === 1'b1) pk_pos[k]++;
    apply();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_model();
    apply();
    tick();
    tick();
    rst = 1'b0;
    clr_model();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mst_tready = 1'b1;
    clr_model();
    load(0, 0, 8'h77, 1'b1);
    apply();
    tick(); tick();
    tests++; if (s_grant !== 4'b0) begin fails++; $display("FAIL reset_grant got=%b exp=0000", s_grant); end
    tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    tests++; if (s_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", s_done); end
    tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got=%b exp=0", s_valid); end
    tests++; if (s_ready !== 4'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0000", s_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] ed [3];
    logic       el [3];
    ed = '{8'hA1, 8'h11, 8'h22};
    el = '{1'b0, 1'b0, 1'b1};
    sel = 1'b0; en = 1'b1; mst_tready = 1'b1;
    do_reset();
    load(1, 0, 8'h11, 1'b0);
    load(1, 1, 8'h22, 1'b1);
    apply();
    for (int c = 0; c < 12; c++) tick();
    tests++; if (n !== 3) begin fails++; $display("FAIL single_count got=%0d exp=3", n); end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (out_d[i] !== ed[i] || out_l[i] !== el[i] || out_g[i] !== 4'b0010) begin
        fails++;
        $display("FAIL single_beat%0d got=%h/%b/%b exp=%h/%b/0010", i, out_d[i], out_l[i], out_g[i], ed[i], el[i]);
      end
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL single_done got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_contention();
    logic [7:0] ed [15];
    ed = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA2, 8'h21, 8'h22,
           8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
    sel = 1'b0; en = 1'b1; mst_tready = 1'b1;
    do_reset();
    load(0, 0, 8'h01, 1'b0); load(0, 1, 8'h02, 1'b1);
    load(0, 2, 8'h03, 1'b0); load(0, 3, 8'h04, 1'b1);
    for (int k = 1; k < 4; k++) begin
      load(k, 0, 8'(k*16 + 1), 1'b0);
      load(k, 1, 8'(k*16 + 2), 1'b1);
    end
    apply();
    for (int c = 0; c < 40; c++) tick();
    tests++; if (n !== 15) begin fails++; $display("FAIL cont_count got=%0d exp=15", n); end
    for (int i = 0; i < 15; i++) begin
      tests++;
      if (out_d[i] !== ed[i] || out_l[i] !== (i % 3 == 2)) begin
        fails++;
        $display("FAIL cont_beat%0d got=%h/%b exp=%h/%b", i, out_d[i], out_l[i], ed[i], (i % 3 == 2));
      end
    end
    for (int p = 0; p < 4; p++) begin
      tests++;
      if (out_c[3*p+3] - out_c[3*p+2] !== 2) begin
        fails++;
        $display("FAIL cont_gap%0d got=%0d exp=2", p, out_c[3*p+3] - out_c[3*p+2]);
      end
    end
    tests++; if (done_cnt !== 5) begin fails++; $display("FAIL cont_done got=%0d exp=5", done_cnt); end
  endtask

  task automatic test_backpressure();
    logic       pat [4];
    logic [7:0] ed [4];
    logic [3:0] er;
    logic [7:0] prev_d;
    logic       prev_v, prev_r;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    ed  = '{8'hA3, 8'h31, 8'h32, 8'h33};
    sel = 1'b0; en = 1'b1; mst_tready = 1'b1;
    do_reset();
    load(3, 0, 8'h31, 1'b0); load(3, 1, 8'h32, 1'b0); load(3, 2, 8'h33, 1'b1);
    apply();
    prev_v = 1'b0; prev_r = 1'b1; prev_d = 8'h00;
    for (int c = 0; c < 24; c++) begin
      mst_tready = pat[c % 4];
      tick();
      if (prev_v && !prev_r) begin
        tests++;
        if (s_valid !== 1'b1 || s_data !== prev_d) begin
          fails++;
          $display("FAIL bp_hold c%0d got=%b/%h exp=1/%h", c, s_valid, s_data, prev_d);
        end
      end
      er = (s_busy === 1'b1 && s_data !== 8'hA3 && mst_tready) ? 4'b1000 : 4'b0000;
      tests++;
      if (s_ready !== er) begin fails++; $display("FAIL bp_ready c%0d got=%b exp=%b", c, s_ready, er); end
      prev_v = s_valid; prev_r = mst_tready; prev_d = s_data;
    end
    tests++; if (n !== 4) begin fails++; $display("FAIL bp_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_d[i] !== ed[i]) begin fails++; $display("FAIL bp_beat%0d got=%h exp=%h", i, out_d[i], ed[i]); end
    end
    mst_tready = 1'b1;
  endtask

  task automatic test_enable();
    logic [7:0] ed [7];
    ed = '{8'hA2, 8'h21, 8'h22, 8'h23, 8'hA3, 8'h31, 8'h32};
    sel = 1'b0; en = 1'b1; mst_tready = 1'b1;
    do_reset();
    load(2, 0, 8'h21, 1'b0); load(2, 1, 8'h22, 1'b0); load(2, 2, 8'h23, 1'b1);
    load(3, 0, 8'h31, 1'b0); load(3, 1, 8'h32, 1'b1);
    apply();
    for (int c = 0; c < 20; c++) begin
      tick();
      if (n >= 2) break;
    end
    en = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    tests++; if (n !== 4) begin fails++; $display("FAIL en_off_count got=%0d exp=4", n); end
    tests++; if (s_grant !== 4'b0 || s_busy !== 1'b0) begin fails++; $display("FAIL en_off_grant got=%b/%b exp=0000/0", s_grant, s_busy); end
    en = 1'b1;
    tick();
    tests++; if (s_grant !== 4'b0) begin fails++; $display("FAIL en_arb_cycle got=%b exp=0000", s_grant); end
    tick();
    tests++;
    if (s_grant !== 4'b1000 || s_valid !== 1'b1 || s_data !== 8'hA3) begin
      fails++;
      $display("FAIL en_regrant got=%b/%b/%h exp=1000/1/a3", s_grant, s_valid, s_data);
    end
    for (int c = 0; c < 6; c++) tick();
    tests++; if (n !== 7) begin fails++; $display("FAIL en_total got=%0d exp=7", n); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if (out_d[i] !== ed[i]) begin fails++; $display("FAIL en_beat%0d got=%h exp=%h", i, out_d[i], ed[i]); end
    end
    tests++; if (out_l[3] !== 1'b1 || out_l[6] !== 1'b1) begin fails++; $display("FAIL en_last got=%b%b exp=11", out_l[3], out_l[6]); end
  endtask

  task automatic test_no_header();
    sel = 1'b1; en = 1'b1; mst_tready = 1'b1;
    do_reset();
    load(0, 0, 8'h5A, 1'b1);
    apply();
    for (int c = 0; c < 8; c++) tick();
    tests++; if (n !== 1) begin fails++; $display("FAIL nohdr_count got=%0d exp=1", n); end
    tests++;
    if (out_d[0] !== 8'h5A || out_l[0] !== 1'b1 || out_g[0] !== 4'b0001) begin
      fails++;
      $display("FAIL nohdr_beat got=%h/%b/%b exp=5a/1/0001", out_d[0], out_l[0], out_g[0]);
    end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL nohdr_done got=%0d exp=1", done_cnt); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] ed [4];
    ed = '{8'hA0, 8'h51, 8'hA1, 8'h61};
    sel = 1'b0; en = 1'b1; mst_tready = 1'b1;
    do_reset();
    load(1, 0, 8'h41, 1'b0); load(1, 1, 8'h42, 1'b0);
    load(1, 2, 8'h43, 1'b0); load(1, 3, 8'h44, 1'b1);
    apply();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (n >= 2) break;
    end
    tests++; if (s_busy !== 1'b1) begin fails++; $display("FAIL rmid_pre_busy got=%b exp=1", s_busy); end
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (s_grant !== 4'b0 || s_busy !== 1'b0 || s_valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_state got=%b/%b/%b exp=0000/0/0", s_grant, s_busy, s_valid);
    end
    rst = 1'b0;
    clr_model();
    load(0, 0, 8'h51, 1'b1);
    load(1, 0, 8'h61, 1'b1);
    apply();
    for (int c = 0; c < 12; c++) tick();
    tests++; if (n !== 4) begin fails++; $display("FAIL rmid_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_d[i] !== ed[i]) begin fails++; $display("FAIL rmid_beat%0d got=%h exp=%h", i, out_d[i], ed[i]); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mst_tready = 1'b0;
    slv_tdata = '0; slv_tvalid = '0; slv_tlast = '0;
    clr_model();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_enable();
    test_no_header();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
